// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: front-end redirect sequencer for taken branches and RET/RTI stack pops
//   in : clk, rst_n, ex_valid, btype[2:0], b_take, target_addr[AW], sp_in[AW], mem_ack, mem_rdata[AW]
//   out: busy, pc_load, pc_target[AW], flush_ifid, flush_idex, mem_req, mem_addr[AW], redirect_count[CNT_W]
module branch_redirect_ctrl #(
  parameter int AW           = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [2:0]       btype,
  input  logic             b_take,
  input  logic [AW-1:0]    target_addr,
  input  logic [AW-1:0]    sp_in,
  input  logic             mem_ack,
  input  logic [AW-1:0]    mem_rdata,
  output logic             busy,
  output logic             pc_load,
  output logic [AW-1:0]    pc_target,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             mem_req,
  output logic [AW-1:0]    mem_addr,
  output logic [CNT_W-1:0] redirect_count
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RET_REQ = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;
  localparam logic [3:0] FC_INIT = 4'(FLUSH_CYCLES - 1);
  logic [1:0]    state;
  logic [3:0]    fcnt;
  logic          accept;
  logic          redirect;
  logic [AW-1:0] new_pc;
  assign busy = state != IDLE;
  always_comb begin
    accept   = state == IDLE && ex_valid && b_take && btype != 3'b000;
    redirect = (accept && btype != 3'b111) || (state == RET_REQ && mem_ack);
    new_pc   = state == RET_REQ ? mem_rdata : target_addr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      fcnt           <= '0;
      pc_load        <= 1'b0;
      pc_target      <= '0;
      flush_ifid     <= 1'b0;
      flush_idex     <= 1'b0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      redirect_count <= '0;
    end else begin
      pc_load <= redirect;
      if (redirect) begin
        pc_target      <= new_pc;
        flush_ifid     <= 1'b1;
        flush_idex     <= 1'b1;
        fcnt           <= FC_INIT;
        redirect_count <= redirect_count + 1'b1;
        mem_req        <= 1'b0;
        state          <= FLUSH;
      end else if (accept) begin
        mem_addr <= sp_in;
        mem_req  <= 1'b1;
        state    <= RET_REQ;
      end else if (state == FLUSH) begin
        if (fcnt == 4'd0) begin
          flush_ifid <= 1'b0;
          flush_idex <= 1'b0;
          state      <= IDLE;
        end else fcnt <= fcnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: scoreboard bench for two branch_redirect_ctrl builds sharing one stimulus stream
module tb_branch_redirect_ctrl;
  typedef struct {
    logic        busy;
    logic        flush;
    logic        req;
    logic        ld;
    logic [7:0]  addr;
    logic [7:0]  tgt;
    logic [15:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ex_valid = 1'b0;
  logic [2:0] btype = 3'd0;
  logic b_take = 1'b0;
  logic [7:0] target_addr = 8'd0;
  logic [7:0] sp_in = 8'd0;
  logic mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'd0;
  logic busy0, ld0, fi0, fe0, req0, busy1, ld1, fi1, fe1, req1;
  logic [7:0] tgt0, addr0, tgt1, addr1;
  logic [15:0] cnt0;
  logic [3:0] cnt1;
  int nv = 0;
  int ne = 0;
  int m_mode[2];
  int m_rem[2];
  int m_cnt[2];
  logic [7:0] m_tgt[2];
  logic [7:0] m_sp[2];
  int fc[2] = '{2, 1};
  int cmod[2] = '{65536, 16};
  exp_t q0[$];
  exp_t q1[$];
  always #5 clk = ~clk;
  branch_redirect_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .btype(btype), .b_take(b_take),
    .target_addr(target_addr), .sp_in(sp_in), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy0), .pc_load(ld0), .pc_target(tgt0), .flush_ifid(fi0), .flush_idex(fe0),
    .mem_req(req0), .mem_addr(addr0), .redirect_count(cnt0)
  );
  branch_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .btype(btype), .b_take(b_take),
    .target_addr(target_addr), .sp_in(sp_in), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy1), .pc_load(ld1), .pc_target(tgt1), .flush_ifid(fi1), .flush_idex(fe1),
    .mem_req(req1), .mem_addr(addr1), .redirect_count(cnt1)
  );
  task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    nv++;
    if (a !== e) begin
      ne++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, k, a, e, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_rem[k] = 0; m_cnt[k] = 0; m_tgt[k] = 8'd0; m_sp[k] = 8'd0;
    end
    q0.delete();
    q1.delete();
  endtask
  task automatic go(input int k, input logic [7:0] t);
    m_mode[k] = 2;
    m_rem[k]  = fc[k];
    m_tgt[k]  = t;
    m_cnt[k]  = (m_cnt[k] + 1) % cmod[k];
  endtask
  task automatic step(input int k);
    exp_t e;
    e.ld = 1'b0;
    if (m_mode[k] == 0) begin
      if (ex_valid && b_take && btype != 3'd0) begin
        if (btype == 3'd7) begin
          m_mode[k] = 1;
          m_sp[k]   = sp_in;
        end else begin
          go(k, target_addr);
          e.ld = 1'b1;
        end
      end
    end else if (m_mode[k] == 1) begin
      if (mem_ack) begin
        go(k, mem_rdata);
        e.ld = 1'b1;
      end
    end else begin
      m_rem[k]--;
      if (m_rem[k] == 0) m_mode[k] = 0;
    end
    e.busy  = m_mode[k] != 0;
    e.flush = m_mode[k] == 2;
    e.req   = m_mode[k] == 1;
    e.addr  = m_sp[k];
    e.tgt   = m_tgt[k];
    e.cnt   = 16'(m_cnt[k]);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic cyc(input logic ev, input logic [2:0] bt, input logic tk, input logic [7:0] tg,
                     input logic [7:0] sp, input logic ak, input logic [7:0] rd);
    ex_valid = ev; btype = bt; b_take = tk; target_addr = tg; sp_in = sp; mem_ack = ak; mem_rdata = rd;
    step(0);
    step(1);
    @(negedge clk);
  endtask
  task automatic rchk();
    chk("rst_busy", 0, 32'(busy0), 0); chk("rst_load", 0, 32'(ld0), 0);
    chk("rst_tgt", 0, 32'(tgt0), 0);   chk("rst_fi", 0, 32'(fi0), 0);
    chk("rst_fe", 0, 32'(fe0), 0);     chk("rst_req", 0, 32'(req0), 0);
    chk("rst_addr", 0, 32'(addr0), 0); chk("rst_cnt", 0, 32'(cnt0), 0);
    chk("rst_busy", 1, 32'(busy1), 0); chk("rst_req", 1, 32'(req1), 0);
    chk("rst_load", 1, 32'(ld1), 0);   chk("rst_cnt", 1, 32'(cnt1), 0);
  endtask
  task automatic cmp(input int k, input exp_t e, input logic b, input logic fi, input logic fe,
                     input logic rq, input logic [7:0] ad, input logic ld, input logic [7:0] tg,
                     input logic [15:0] ct);
    chk("busy", k, 32'(b), 32'(e.busy));
    chk("flush_ifid", k, 32'(fi), 32'(e.flush));
    chk("flush_idex", k, 32'(fe), 32'(e.flush));
    chk("mem_req", k, 32'(rq), 32'(e.req));
    if (e.req) chk("mem_addr", k, 32'(ad), 32'(e.addr));
    chk("pc_load", k, 32'(ld), 32'(e.ld));
    chk("pc_target", k, 32'(tg), 32'(e.tgt));
    chk("redirect_count", k, 32'(ct), 32'(e.cnt));
  endtask
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        nv++; ne++;
        $display("FAIL scoreboard_underflow got %0d/%0d entries expected 1 at %0t", q0.size(), q1.size(), $time);
      end else begin
        cmp(0, q0.pop_front(), busy0, fi0, fe0, req0, addr0, ld0, tgt0, cnt0);
        cmp(1, q1.pop_front(), busy1, fi1, fe1, req1, addr1, ld1, tgt1, {12'd0, cnt1});
      end
    end
  end
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rchk();
    rst_n = 1'b1;
    cyc(1, 3'd1, 1, 8'h3C, 8'h00, 0, 8'h00);
    repeat (4) cyc(0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h00);
    cyc(1, 3'd7, 1, 8'hAA, 8'hF0, 0, 8'h00);
    cyc(0, 3'd0, 0, 8'h00, 8'h11, 0, 8'h99);
    cyc(0, 3'd0, 0, 8'h00, 8'h22, 0, 8'h99);
    cyc(0, 3'd0, 0, 8'h00, 8'h33, 1, 8'h42);
    repeat (4) cyc(0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h00);
    cyc(1, 3'd6, 1, 8'h55, 8'h00, 0, 8'h00);
    repeat (3) cyc(1, 3'd6, 1, 8'h10, 8'h00, 0, 8'h00);
    repeat (4) cyc(0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h00);
    cyc(1, 3'd0, 1, 8'h77, 8'h00, 0, 8'h00);
    cyc(1, 3'd2, 0, 8'h78, 8'h00, 0, 8'h00);
    cyc(0, 3'd0, 0, 8'h00, 8'h00, 1, 8'h66);
    repeat (2000)
      cyc($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 2) != 0, 8'($urandom),
          8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom));
    repeat (6) cyc(0, 3'd0, 0, 8'h00, 8'h00, 1, 8'h5A);
    repeat (4) cyc(0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h00);
    cyc(1, 3'd7, 1, 8'h00, 8'hC4, 0, 8'h00);
    repeat (2) cyc(0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h00);
    rst_n = 1'b0;
    #1;
    rchk();
    model_reset();
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    repeat (3) @(negedge clk);
    chk("rst_hold_load", 0, 32'(ld0), 0);
    rst_n = 1'b1;
    cyc(0, 3'd0, 0, 8'h00, 8'h00, 1, 8'hEE);
    cyc(0, 3'd0, 0, 8'h00, 8'h00, 1, 8'hEE);
    cyc(1, 3'd1, 1, 8'h21, 8'h00, 0, 8'h00);
    repeat (4) cyc(0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
    $finish;
  end
endmodule
